io_input_reader: RTL and testbench

IO_INPUT_READER -- requirements
Module: io_input_reader

---
 rtl/io_input_reader.sv | 129 ++++++++++++
 tb/tb_io_input_reader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/io_input_reader.sv
// io_input_reader: synchronizes, debounces and edge-detects 5 pushbuttons and 24 DIP switches.
// Long-press detection is built only when IO_READER_LONG_PRESS_EN is defined.
module io_input_reader #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned LONG_CYCLES     = 100000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  io_button,
    input  logic [23:0] io_dip,
    output logic [4:0]  btn_level,
    output logic [4:0]  btn_press,
    output logic [4:0]  btn_release,
    output logic [4:0]  btn_long,
    output logic [23:0] dip_value,
    output logic        dip_changed
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic [4:0]          btn_s1_q, btn_s2_q;
    logic [23:0]         dip_s1_q, dip_s2_q, dip_prev_q;
    logic [4:0][DW-1:0]  btn_cnt_q, btn_cnt_d;
    logic [DW-1:0]       dip_cnt_q, dip_cnt_d;
    logic [4:0]          level_q, level_d, press_q, press_d, release_q, release_d;
    logic [23:0]         dip_value_q, dip_value_d;
    logic                dip_changed_q, dip_changed_d;

    always_comb begin
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        for (int b = 0; b < 5; b++) begin
            btn_cnt_d[b] = '0;
            if (btn_s2_q[b] != level_q[b]) begin
                if (btn_cnt_q[b] == DEB_LAST) begin
                    level_d[b]   = btn_s2_q[b];
                    press_d[b]   = btn_s2_q[b];
                    release_d[b] = ~btn_s2_q[b];
                end else begin
                    btn_cnt_d[b] = btn_cnt_q[b] + 1'b1;
                end
            end
        end
    end

    // The DIP counter parks at its last value once the vector is stable, so a
    // settled vector equal to dip_value never pulses again.
    always_comb begin
        dip_cnt_d     = dip_cnt_q;
        dip_value_d   = dip_value_q;
        dip_changed_d = 1'b0;
        if (dip_s2_q != dip_prev_q) begin
            dip_cnt_d = '0;
        end else if (dip_cnt_q != DEB_LAST) begin
            dip_cnt_d = dip_cnt_q + 1'b1;
        end else if (dip_s2_q != dip_value_q) begin
            dip_value_d   = dip_s2_q;
            dip_changed_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_s1_q      <= '0;
            btn_s2_q      <= '0;
            dip_s1_q      <= '0;
            dip_s2_q      <= '0;
            dip_prev_q    <= '0;
            btn_cnt_q     <= '0;
            dip_cnt_q     <= '0;
            level_q       <= '0;
            press_q       <= '0;
            release_q     <= '0;
            dip_value_q   <= '0;
            dip_changed_q <= 1'b0;
        end else begin
            btn_s1_q      <= io_button;
            btn_s2_q      <= btn_s1_q;
            dip_s1_q      <= io_dip;
            dip_s2_q      <= dip_s1_q;
            dip_prev_q    <= dip_s2_q;
            btn_cnt_q     <= btn_cnt_d;
            dip_cnt_q     <= dip_cnt_d;
            level_q       <= level_d;
            press_q       <= press_d;
            release_q     <= release_d;
            dip_value_q   <= dip_value_d;
            dip_changed_q <= dip_changed_d;
        end
    end

`ifdef IO_READER_LONG_PRESS_EN
    localparam int LW = $clog2(LONG_CYCLES + 1);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);
    localparam logic [LW-1:0] LONG_SAT  = LW'(LONG_CYCLES);

    logic [4:0][LW-1:0] hold_q, hold_d;
    logic [4:0]         long_q, long_d;

    // Saturating one past the trigger value makes the pulse fire once per press.
    always_comb begin
        for (int b = 0; b < 5; b++) begin
            hold_d[b] = !level_q[b] ? '0 : (hold_q[b] == LONG_SAT) ? hold_q[b] : hold_q[b] + 1'b1;
            long_d[b] = level_q[b] && (hold_q[b] == LONG_LAST);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
            long_q <= '0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign btn_long = long_q;
`else
    assign btn_long = '0;
`endif

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign dip_value   = dip_value_q;
    assign dip_changed = dip_changed_q;
endmodule

// File: tb/tb_io_input_reader.sv
// tb_io_input_reader: directed stimulus with a history-window reference model checked every cycle.
module tb_io_input_reader;
    localparam int DEB  = 4;
    localparam int LONG = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  io_button;
    logic [23:0] io_dip;
    logic [4:0]  btn_level, btn_press, btn_release, btn_long;
    logic [23:0] dip_value;
    logic        dip_changed;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    io_input_reader #(.DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG)) dut (
        .clk(clk), .rst(rst), .io_button(io_button), .io_dip(io_dip),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
        .btn_long(btn_long), .dip_value(dip_value), .dip_changed(dip_changed)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: raw input history (index 0 newest); an input is accepted
    // once the synchronized value (two samples old) has held long enough.
    logic [4:0]  rh_b [DEB+2];
    logic [23:0] rh_d [DEB+2];
    logic [4:0]  m_level = '0, m_press = '0, m_release = '0, m_long = '0;
    logic [23:0] m_dip = '0;
    logic        m_changed = 1'b0;
    logic        all_opp, same;
    int          hr [5];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEB + 2; i++) begin
                rh_b[i] = '0;
                rh_d[i] = '0;
            end
            for (int b = 0; b < 5; b++) hr[b] = 0;
            m_level = '0; m_press = '0; m_release = '0; m_long = '0;
            m_dip = '0; m_changed = 1'b0;
        end else begin
            m_long = '0;
            m_press = '0;
            m_release = '0;
            for (int b = 0; b < 5; b++) begin
`ifdef IO_READER_LONG_PRESS_EN
                m_long[b] = (hr[b] == LONG);
`endif
                all_opp = 1'b1;
                for (int i = 1; i <= DEB; i++)
                    if (rh_b[i][b] == m_level[b]) all_opp = 1'b0;
                if (all_opp) begin
                    m_level[b] = ~m_level[b];
                    if (m_level[b]) m_press[b] = 1'b1;
                    else m_release[b] = 1'b1;
                end
                hr[b] = m_level[b] ? ((hr[b] > LONG) ? hr[b] : hr[b] + 1) : 0;
            end
            same = 1'b1;
            for (int i = 2; i <= DEB + 1; i++)
                if (rh_d[i] != rh_d[1]) same = 1'b0;
            m_changed = same && (rh_d[1] != m_dip);
            if (m_changed) m_dip = rh_d[1];
            for (int i = DEB + 1; i > 0; i--) begin
                rh_b[i] = rh_b[i-1];
                rh_d[i] = rh_d[i-1];
            end
            rh_b[0] = io_button;
            rh_d[0] = io_dip;
        end
    end

    always @(posedge clk) begin
        #1;
        chk("level",   32'(btn_level),   32'(m_level));
        chk("press",   32'(btn_press),   32'(m_press));
        chk("release", 32'(btn_release), 32'(m_release));
        chk("long",    32'(btn_long),    32'(m_long));
        chk("dip",     32'(dip_value),   32'(m_dip));
        chk("changed", 32'(dip_changed), 32'(m_changed));
    end

    int rise_at, long_at, long_n, dc_n;

    initial begin
        rst = 1'b1;
        io_button = '0;
        io_dip = '0;
        repeat (3) @(negedge clk);
        chk("rst_level", 32'(btn_level), 32'h0);
        chk("rst_dip", 32'(dip_value), 32'h0);
        rst = 1'b0;

        // single press on bit 0
        @(negedge clk);
        io_button[0] = 1'b1;
        repeat (5) @(posedge clk);
        #1 chk("b0_early", 32'(btn_level), 32'h0);
        @(posedge clk);
        #1 chk("b0_rise", 32'(btn_level), 32'h01);
        chk("b0_press", 32'(btn_press), 32'h01);
        @(posedge clk);
        #1 chk("b0_press_end", 32'(btn_press), 32'h0);

        // bounce shorter than the debounce window on bit 1
        @(negedge clk);
        io_button[1] = 1'b1;
        repeat (3) @(negedge clk);
        io_button[1] = 1'b0;
        repeat (2) @(negedge clk);
        io_button[1] = 1'b1;
        repeat (3) @(negedge clk);
        io_button[1] = 1'b0;
        repeat (8) @(negedge clk);
        chk("b1_bounce", 32'(btn_level), 32'h01);

        // DIP change with a toggle before settling, then a glitch back to the same value
        io_dip = 24'h0000A5;
        repeat (2) @(negedge clk);
        io_dip = 24'h0000A4;
        repeat (6) @(posedge clk);
        #1 chk("dip_early", 32'(dip_value), 32'h0);
        @(posedge clk);
        #1 chk("dip_load", 32'(dip_value), 32'h0000A4);
        chk("dip_pulse", 32'(dip_changed), 32'h1);
        @(negedge clk);
        io_dip = 24'h0000A5;
        @(negedge clk);
        io_dip = 24'h0000A4;
        dc_n = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1 if (dip_changed) dc_n++;
        end
        chk("dip_repulse", 32'(dc_n), 32'h0);
        chk("dip_hold", 32'(dip_value), 32'h0000A4);

        // long hold on bit 2
        @(negedge clk);
        io_button[2] = 1'b1;
        rise_at = -1; long_at = -1; long_n = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (btn_press[2]) rise_at = c;
            if (btn_long[2]) begin
                long_n++;
                long_at = c;
            end
        end
        chk("b2_rise", 32'(rise_at), 32'd6);
`ifdef IO_READER_LONG_PRESS_EN
        chk("long_count", 32'(long_n), 32'd1);
        chk("long_offset", 32'(long_at - rise_at), 32'd16);
`else
        chk("long_count", 32'(long_n), 32'd0);
`endif
        @(negedge clk);
        io_button[2] = 1'b0;
        repeat (8) @(negedge clk);

        // simultaneous release on bits 3 and 4
        io_button[4:3] = 2'b11;
        repeat (8) @(negedge clk);
        chk("b34_level", 32'(btn_level), 32'h19);
        io_button[4:3] = 2'b00;
        repeat (5) @(posedge clk);
        #1 chk("b34_early", 32'(btn_release), 32'h0);
        @(posedge clk);
        #1 chk("b34_release", 32'(btn_release), 32'h18);
        chk("b34_nopress", 32'(btn_press), 32'h0);
        chk("b34_level_after", 32'(btn_level), 32'h01);

        // asynchronous reset mid-debounce, then inputs already high at release
        @(negedge clk);
        io_button = 5'b10110;
        io_dip = 24'h5A3C71;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_level", 32'(btn_level), 32'h0);
        chk("arst_press", 32'(btn_press), 32'h0);
        chk("arst_release", 32'(btn_release), 32'h0);
        chk("arst_long", 32'(btn_long), 32'h0);
        chk("arst_dip", 32'(dip_value), 32'h0);
        chk("arst_changed", 32'(dip_changed), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1 chk("post_rst_early", 32'(btn_level), 32'h0);
        @(posedge clk);
        #1 chk("post_rst_level", 32'(btn_level), 32'h16);
        chk("post_rst_press", 32'(btn_press), 32'h16);
        @(posedge clk);
        #1 chk("post_rst_dip", 32'(dip_value), 32'h5A3C71);
        chk("post_rst_changed", 32'(dip_changed), 32'h1);
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
